// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the instruction-memory request/response and the
// fetch-bundle/redirect signals between the fetch stage and its neighbours.
//   master : fetch stage side (drives imem request and fetch bundle)
//   slave  : environment side (memory, dispatch, execute)
interface fetch_stage_if;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        ihit;
    logic [31:0] imem_load;
    logic        freeze;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_miss;
    logic [31:0] branch_target;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;

    modport master (
        output imem_ren, imem_addr, fetch_valid, fetch_instr, fetch_pc,
        input  ihit, imem_load, freeze, jump, jump_target, branch_miss, branch_target
    );

    modport slave (
        input  imem_ren, imem_addr, fetch_valid, fetch_instr, fetch_pc,
        output ihit, imem_load, freeze, jump, jump_target, branch_miss, branch_target
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch. Holds the PC, issues one outstanding read
// at a time and buffers returned words in a QDEPTH-entry circular queue whose
// head is the fetch bundle for dispatch. branch_miss / jump flush the queue
// and restart fetch at the target (branch_miss wins).
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   bus (master)       imem_ren/imem_addr/ihit/imem_load memory side,
//                      freeze/jump/jump_target dispatch side,
//                      branch_miss/branch_target execute side,
//                      fetch_valid/fetch_instr/fetch_pc fetch bundle
//   perf_fetched/perf_stall/perf_flush  saturating counters, present only
//                      when FETCH_PERF_CNT_EN is defined
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall,
    output logic [15:0]   perf_flush
`endif
);
    localparam int            PW    = $clog2(QDEPTH);
    localparam logic [PW:0]   QFULL = (PW+1)'(QDEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          q [QDEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [PW:0]     count;
    logic [31:0]     pc;

    logic            redirect, enq, deq;
    logic [31:0]     target;

    assign redirect = bus.branch_miss || bus.jump;
    assign target   = bus.branch_miss ? bus.branch_target : bus.jump_target;

    // Request drops while full or redirecting; the memory sees that as an
    // abandoned request, so any same-cycle ihit is ignored.
    assign bus.imem_ren  = (count != QFULL) && !redirect && !RST;
    assign bus.imem_addr = pc;

    assign bus.fetch_valid = (count != '0) && !redirect && !RST;
    assign bus.fetch_instr = q[rd_ptr].instr;
    assign bus.fetch_pc    = q[rd_ptr].pc;

    assign enq = bus.imem_ren && bus.ihit;
    assign deq = bus.fetch_valid && !bus.freeze;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc     <= {RESET_PC[31:2], 2'b00};
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
        end else if (redirect) begin
            pc     <= {target[31:2], 2'b00};
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (enq) begin
                q[wr_ptr] <= '{pc: pc, instr: bus.imem_load};
                wr_ptr    <= wr_ptr + 1'b1;
                pc        <= pc + 32'd4;
            end
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else begin
            if (enq && perf_fetched != '1)
                perf_fetched <= perf_fetched + 1'b1;
            if (bus.imem_ren && !bus.ihit && perf_stall != '1)
                perf_stall <= perf_stall + 1'b1;
            if (redirect && perf_flush != '1)
                perf_flush <= perf_flush + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
    logic [15:0] perf_flush;
`endif

    fetch_stage #(.RESET_PC(32'h0), .QDEPTH(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory model: word at address A is A ^ 0xDEAD0000.
    assign bus.imem_load = bus.imem_addr ^ 32'hDEAD_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.ihit = 1'b0; bus.freeze = 1'b0;
        bus.jump = 1'b0; bus.jump_target = '0;
        bus.branch_miss = 1'b0; bus.branch_target = '0;
        @(negedge CLK);
        chk("rst_ren", 32'(bus.imem_ren), 32'd0);
        chk("rst_valid", 32'(bus.fetch_valid), 32'd0);
        nxt();
        nxt();
        @(negedge CLK);
        chk("rst_pc", bus.fetch_pc, 32'h0);
        chk("rst_instr", bus.fetch_instr, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        nxt();
        RST = 1'b0;
    endtask

    initial begin
        // reset then streaming fetch
        do_reset();
        bus.ihit = 1'b1;
        @(negedge CLK);
        chk("c1_ren", 32'(bus.imem_ren), 32'd1);
        chk("c1_addr", bus.imem_addr, 32'h0);
        chk("c1_valid", 32'(bus.fetch_valid), 32'd0);
        nxt();
        @(negedge CLK);
        chk("c2_addr", bus.imem_addr, 32'h4);
        chk("c2_valid", 32'(bus.fetch_valid), 32'd1);
        chk("c2_pc", bus.fetch_pc, 32'h0);
        chk("c2_instr", bus.fetch_instr, 32'hDEAD_0000);
        nxt();
        @(negedge CLK);
        chk("c3_addr", bus.imem_addr, 32'h8);
        chk("c3_pc", bus.fetch_pc, 32'h4);

        // freeze fills the queue; reset mid-operation first
        nxt();
        do_reset();
        bus.ihit = 1'b1; bus.freeze = 1'b1;
        nxt();                                  // cycle1: enqueue 0x0
        for (int k = 0; k < 3; k++) begin       // cycles 2..4
            @(negedge CLK);
            chk("frz_head", bus.fetch_pc, 32'h0);
            chk("frz_ren", 32'(bus.imem_ren), 32'd1);
            nxt();
        end
        @(negedge CLK);                         // cycle5: full
        chk("full_ren", 32'(bus.imem_ren), 32'd0);
        chk("full_addr", bus.imem_addr, 32'h10);
        chk("full_head", bus.fetch_pc, 32'h0);
        nxt();
        bus.freeze = 1'b0; bus.ihit = 1'b0;     // cycle6: first pop
        @(negedge CLK);
        chk("pop0_pc", bus.fetch_pc, 32'h0);
        chk("pop0_ren", 32'(bus.imem_ren), 32'd0);
        nxt();
        for (int k = 1; k < 4; k++) begin       // cycles 7..9
            @(negedge CLK);
            chk("pop_pc", bus.fetch_pc, 32'(k * 4));
            chk("pop_ren", 32'(bus.imem_ren), 32'd1);
            chk("pop_addr", bus.imem_addr, 32'h10);
            nxt();
        end
        @(negedge CLK);                         // cycle10: empty
        chk("empty_valid", 32'(bus.fetch_valid), 32'd0);

        // jump with 3 entries queued and a hit in the redirect cycle
        bus.freeze = 1'b1; bus.ihit = 1'b1;
        nxt(); nxt(); nxt();                    // enqueue 0x10,0x14,0x18
        bus.jump = 1'b1; bus.jump_target = 32'h100;
        @(negedge CLK);
        chk("jmp_valid", 32'(bus.fetch_valid), 32'd0);
        chk("jmp_ren", 32'(bus.imem_ren), 32'd0);
        nxt();
        bus.jump = 1'b0; bus.freeze = 1'b0;
        @(negedge CLK);
        chk("jmp1_ren", 32'(bus.imem_ren), 32'd1);
        chk("jmp1_addr", bus.imem_addr, 32'h100);
        chk("jmp1_valid", 32'(bus.fetch_valid), 32'd0);
        nxt();
        bus.ihit = 1'b0;
        @(negedge CLK);
        chk("jmp2_valid", 32'(bus.fetch_valid), 32'd1);
        chk("jmp2_pc", bus.fetch_pc, 32'h100);
        chk("jmp2_instr", bus.fetch_instr, 32'hDEAD_0100);
        nxt();

        // branch_miss beats jump
        bus.branch_miss = 1'b1; bus.branch_target = 32'h200;
        bus.jump = 1'b1; bus.jump_target = 32'h300;
        @(negedge CLK);
        chk("bm_ren", 32'(bus.imem_ren), 32'd0);
        nxt();
        bus.branch_miss = 1'b0; bus.jump = 1'b0;
        @(negedge CLK);
        chk("bm_addr", bus.imem_addr, 32'h200);
        chk("bm_valid", 32'(bus.fetch_valid), 32'd0);

        // PC wrap at 2^32, then pointer wrap over 12 streamed entries
        bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
        nxt();
        bus.jump = 1'b0; bus.ihit = 1'b1;
        @(negedge CLK);
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        nxt();
        @(negedge CLK);
        chk("wrap_addr1", bus.imem_addr, 32'h0);
        chk("wrap_head", bus.fetch_pc, 32'hFFFF_FFFC);
        nxt();
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            chk("strm_pc", bus.fetch_pc, 32'(k * 4));
            chk("strm_instr", bus.fetch_instr, 32'(k * 4) ^ 32'hDEAD_0000);
            chk("strm_valid", 32'(bus.fetch_valid), 32'd1);
            nxt();
        end

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        @(negedge CLK);
        chk("perf_rst", perf_stall, 32'd0);
        for (int k = 0; k < 5; k++) nxt();      // 5 requested cycles, no hit
        bus.jump = 1'b1; bus.jump_target = 32'h40;
        nxt();
        bus.jump = 1'b0;
        @(negedge CLK);
        chk("perf_stall", perf_stall, 32'd5);
        chk("perf_flush", 32'(perf_flush), 32'd1);
        chk("perf_fetched", perf_fetched, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
